// File: rtl/regfile_wr_arb_pkg.sv
// rtl/regfile_wr_arb_pkg.sv - shared widths, requester encoding and constants for the register-file write arbiter
package regfile_wr_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int N_REQ  = 2;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_e;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_wr_arb_if.sv
// rtl/regfile_wr_arb_if.sv - producer request/grant signals and the register-file write port
interface regfile_wr_arb_if;
  import regfile_wr_arb_pkg::*;

  logic              Hold;
  logic              Alu_req;
  logic [ADDR_W-1:0] Alu_wr;
  logic [DATA_W-1:0] Alu_d;
  logic              Alu_gnt;
  logic              Mem_req;
  logic [ADDR_W-1:0] Mem_wr;
  logic [DATA_W-1:0] Mem_d;
  logic              Mem_gnt;
  logic [ADDR_W-1:0] Wr;
  logic [DATA_W-1:0] D;
  logic              We;

  modport master (
    output Hold, Alu_req, Alu_wr, Alu_d, Mem_req, Mem_wr, Mem_d,
    input  Alu_gnt, Mem_gnt, Wr, D, We
  );

  modport slave (
    input  Hold, Alu_req, Alu_wr, Alu_d, Mem_req, Mem_wr, Mem_d,
    output Alu_gnt, Mem_gnt, Wr, D, We
  );

endinterface

// File: rtl/regfile_arb_pick.sv
// rtl/regfile_arb_pick.sv - combinational 2-way picker; on contention the requester named by ptr_i wins
module regfile_arb_pick
  import regfile_wr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic             hold_i,
  input  logic             clr_i,
  input  logic             ptr_i,
  output logic [N_REQ-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (!clr_i && !hold_i) begin
      if (req_i == 2'b11) begin
        gnt_o[ptr_i] = 1'b1;
      end else begin
        gnt_o = req_i;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - register-file write-port arbiter (ALU vs load), r0 suppression, contention counter
// Build option REGFILE_ARB_RR_EN selects round-robin contention; otherwise Mem has fixed priority.
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  regfile_wr_arb_if.slave  bus,
  output logic [CNT_W-1:0] Conf_cnt
);

  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  gnt;
  logic              both_req;
  logic              ptr;

  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign req      = {bus.Mem_req, bus.Alu_req};
  assign both_req = bus.Mem_req & bus.Alu_req;

`ifdef REGFILE_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Contended grant went to ptr_q, so the loser is the other side.
  always_comb begin
    ptr_d = ptr_q;
    if (both_req && (gnt != '0)) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      ptr_q <= REQ_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = REQ_MEM;
`endif

  regfile_arb_pick u_pick (
    .req_i  (req),
    .hold_i (bus.Hold),
    .clr_i  (Clr),
    .ptr_i  (ptr),
    .gnt_o  (gnt)
  );

  assign bus.Alu_gnt = gnt[REQ_ALU];
  assign bus.Mem_gnt = gnt[REQ_MEM];

  always_comb begin
    wr_d = wr_q;
    d_d  = d_q;
    we_d = 1'b0;
    if (gnt[REQ_MEM]) begin
      wr_d = bus.Mem_wr;
      d_d  = bus.Mem_d;
      we_d = (bus.Mem_wr != ZERO_REG);
    end else if (gnt[REQ_ALU]) begin
      wr_d = bus.Alu_wr;
      d_d  = bus.Alu_d;
      we_d = (bus.Alu_wr != ZERO_REG);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (both_req && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      wr_q  <= '0;
      d_q   <= '0;
      we_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      d_q   <= d_d;
      we_q  <= we_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.Wr  = wr_q;
  assign bus.D   = d_q;
  assign bus.We  = we_q;
  assign Conf_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb/tb_regfile_wr_arb.sv - directed self-checking bench for regfile_wr_arb (both REGFILE_ARB_RR_EN builds)
module tb_regfile_wr_arb;

  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Clr;
  logic [CNT_W-1:0] Conf_cnt;
  int               n_chk = 0;
  int               n_bad = 0;

  regfile_wr_arb_if bus ();

  regfile_wr_arb #(.CNT_W(CNT_W)) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .bus      (bus),
    .Conf_cnt (Conf_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.Hold    = 1'b0;
    bus.Alu_req = 1'b0;
    bus.Mem_req = 1'b0;
  endtask

  logic [1:0] exp_gnt [4];
  logic [4:0] exp_wr  [4];

  initial begin
`ifdef REGFILE_ARB_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_wr  = '{5'd1, 5'd2, 5'd1, 5'd2};
`else
    exp_gnt = '{2'b10, 2'b10, 2'b10, 2'b10};
    exp_wr  = '{5'd2, 5'd2, 5'd2, 5'd2};
`endif
    // reset with both requesting
    Clr = 1'b1;
    bus.Hold = 1'b0;
    bus.Alu_req = 1'b1; bus.Alu_wr = 5'd3; bus.Alu_d = 32'hAAAA0003;
    bus.Mem_req = 1'b1; bus.Mem_wr = 5'd4; bus.Mem_d = 32'hBBBB0004;
    step();
    check("rst_gnt0", {bus.Mem_gnt, bus.Alu_gnt}, 2'b00);
    step();
    check("rst_gnt1", {bus.Mem_gnt, bus.Alu_gnt}, 2'b00);
    Clr = 1'b0;
    idle();
    #1;
    check("rst_we",  bus.We, 1'b0);
    check("rst_wr",  bus.Wr, 5'd0);
    check("rst_d",   bus.D, 32'd0);
    check("rst_cnt", Conf_cnt, 4'd0);

    // single ALU write
    step();
    bus.Alu_req = 1'b1; bus.Alu_wr = 5'd5; bus.Alu_d = 32'h12345678;
    #1;
    check("alu_gnt", {bus.Mem_gnt, bus.Alu_gnt}, 2'b01);
    step();
    idle();
    check("alu_we", bus.We, 1'b1);
    check("alu_wr", bus.Wr, 5'd5);
    check("alu_d",  bus.D, 32'h12345678);
    step();
    check("alu_we_off", bus.We, 1'b0);
    check("alu_wr_hold", bus.Wr, 5'd5);

    // r0 write is granted but discarded
    bus.Mem_req = 1'b1; bus.Mem_wr = 5'd0; bus.Mem_d = 32'hFFFFFFFF;
    #1;
    check("r0_gnt", {bus.Mem_gnt, bus.Alu_gnt}, 2'b10);
    step();
    idle();
    check("r0_we", bus.We, 1'b0);
    check("r0_d",  bus.D, 32'hFFFFFFFF);

    // contention for 4 cycles
    bus.Alu_req = 1'b1; bus.Alu_wr = 5'd1; bus.Alu_d = 32'h000000A1;
    bus.Mem_req = 1'b1; bus.Mem_wr = 5'd2; bus.Mem_d = 32'h000000B2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("con_gnt%0d", i), {bus.Mem_gnt, bus.Alu_gnt}, exp_gnt[i]);
      step();
      check($sformatf("con_wr%0d", i), bus.Wr, exp_wr[i]);
      check($sformatf("con_we%0d", i), bus.We, 1'b1);
    end
    idle();
    check("con_cnt", Conf_cnt, 4'd4);

    // hold for 3 cycles, then release
    bus.Hold = 1'b1;
    bus.Alu_req = 1'b1; bus.Alu_wr = 5'd7; bus.Alu_d = 32'h00000077;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold_gnt%0d", i), bus.Alu_gnt, 1'b0);
      step();
      check($sformatf("hold_we%0d", i), bus.We, 1'b0);
    end
    bus.Hold = 1'b0;
    #1;
    check("hold_rel_gnt", bus.Alu_gnt, 1'b1);
    step();
    idle();
    check("hold_rel_we", bus.We, 1'b1);
    check("hold_rel_wr", bus.Wr, 5'd7);
    check("hold_rel_d",  bus.D, 32'h00000077);

    // saturation: count 4 -> 15 after 11 cycles, stays there
    bus.Hold = 1'b1;
    bus.Alu_req = 1'b1; bus.Mem_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) check("sat_cnt14", Conf_cnt, 4'd14);
      if (i == 11) check("sat_cnt15", Conf_cnt, 4'd15);
    end
    check("sat_cnt_end", Conf_cnt, 4'd15);
    check("sat_we", bus.We, 1'b0);

    // Clr while requests pending clears the counter
    Clr = 1'b1;
    bus.Hold = 1'b0;
    #1;
    check("clr_gnt", {bus.Mem_gnt, bus.Alu_gnt}, 2'b00);
    step();
    Clr = 1'b0;
    idle();
    check("clr_cnt", Conf_cnt, 4'd0);

    // in-flight write survives the Clr cycle, then clears
    bus.Alu_req = 1'b1; bus.Alu_wr = 5'd9; bus.Alu_d = 32'h00000099;
    #1;
    check("fly_gnt", bus.Alu_gnt, 1'b1);
    step();
    idle();
    Clr = 1'b1;
    #1;
    check("fly_we", bus.We, 1'b1);
    check("fly_wr", bus.Wr, 5'd9);
    step();
    Clr = 1'b0;
    check("fly_we_clr", bus.We, 1'b0);
    check("fly_wr_clr", bus.Wr, 5'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
